// File: rtl/fir_coeff_loader_pkg.sv
// Shared definitions for the FIR coefficient loaders (direct and transposed form):
// FSM state encodings, default geometry and small helpers.
package fir_coeff_loader_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefNumTaps   = 33;
    localparam int unsigned DefAddrWidth = 6;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StRead  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    function automatic logic is_busy_state(input logic [1:0] st);
        return st != StIdle;
    endfunction

endpackage

// File: rtl/fir_coeff_addr_cnt.sv
// SRAM tap address counter: clears to 0, loads to 1, increments up to NumTaps and holds
// there; tc_o flags the last tap so the counter never wraps.
module fir_coeff_addr_cnt #(
    parameter int unsigned NumTaps   = 33,
    parameter int unsigned AddrWidth = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic                 inc_i,
    output logic [AddrWidth-1:0] cnt_o,
    output logic                 tc_o
);

    localparam logic [AddrWidth-1:0] LastVal = AddrWidth'(NumTaps);

    logic [AddrWidth-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == LastVal);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = AddrWidth'(1);
        end else if (inc_i && !tc_o) begin
            cnt_d = cnt_q + AddrWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// FIR coefficient SRAM loader: streams NUM_TAPS coefficients into addresses 1..NUM_TAPS,
// then read-sweeps them. Optional checksum output enabled by FIR_COEFF_CHECKSUM_EN.
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned NUM_TAPS   = DefNumTaps,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                         iClk_12M,
    input  logic                         iRsn,
    input  logic                         iCoeffUpdate,
    input  logic                         iCoeffValid,
    input  logic signed [DATA_WIDTH-1:0] iCoeffData,
    output logic                         oCoeffReady,
    output logic                         oCsnRam,
    output logic                         oWrnRam,
    output logic [ADDR_WIDTH-1:0]        oAddrRam,
    output logic [DATA_WIDTH-1:0]        oWrDtRam,
    output logic                         oBusy,
    output logic                         oDone,
`ifdef FIR_COEFF_CHECKSUM_EN
    output logic signed [DATA_WIDTH+ADDR_WIDTH-1:0] oCoeffSum,
`endif
    output logic                         oCoeffLoaded
);

    logic [1:0]            state_q, state_d;
    logic                  csn_q, csn_d;
    logic                  wrn_q, wrn_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdt_q, wdt_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  loaded_q, loaded_d;

    logic                  cnt_clr, cnt_load, cnt_inc, cnt_tc;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  start, accept;

    assign start  = (state_q == StIdle) && iCoeffUpdate;
    assign accept = (state_q == StWrite) && iCoeffValid;

    fir_coeff_addr_cnt #(
        .NumTaps   (NUM_TAPS),
        .AddrWidth (ADDR_WIDTH)
    ) u_addr_cnt (
        .clk_i  (iClk_12M),
        .rst_ni (iRsn),
        .clr_i  (cnt_clr),
        .load_i (cnt_load),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        csn_d    = 1'b1;
        wrn_d    = 1'b1;
        addr_d   = addr_q;
        wdt_d    = wdt_q;
        done_d   = 1'b0;
        loaded_d = loaded_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        case (state_q)
            StIdle: begin
                if (iCoeffUpdate) begin
                    state_d  = StWrite;
                    cnt_load = 1'b1;
                    loaded_d = 1'b0;
                end
            end
            StWrite: begin
                // Gap cycles leave the SRAM deselected with address/data held.
                if (accept) begin
                    csn_d  = 1'b0;
                    wrn_d  = 1'b0;
                    addr_d = cnt;
                    wdt_d  = iCoeffData;
                    if (cnt_tc) begin
                        state_d  = StRead;
                        cnt_load = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            StRead: begin
                csn_d  = 1'b0;
                wrn_d  = 1'b1;
                addr_d = cnt;
                wdt_d  = '0;
                if (cnt_tc) begin
                    state_d = StDone;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                // The final read is on the port while here; the pulse lands one cycle later.
                state_d  = StIdle;
                done_d   = 1'b1;
                loaded_d = 1'b1;
                cnt_clr  = 1'b1;
            end
        endcase

        busy_d = is_busy_state(state_d) | done_d;
    end

    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            state_q  <= StIdle;
            csn_q    <= 1'b1;
            wrn_q    <= 1'b1;
            addr_q   <= '0;
            wdt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            csn_q    <= csn_d;
            wrn_q    <= wrn_d;
            addr_q   <= addr_d;
            wdt_q    <= wdt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            loaded_q <= loaded_d;
        end
    end

`ifdef FIR_COEFF_CHECKSUM_EN
    localparam int unsigned SumWidth = DATA_WIDTH + ADDR_WIDTH;

    logic signed [SumWidth-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + $signed({{ADDR_WIDTH{iCoeffData[DATA_WIDTH-1]}}, iCoeffData});
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign oCoeffSum = sum_q;
`endif

    assign oCoeffReady  = (state_q == StWrite);
    assign oCsnRam      = csn_q;
    assign oWrnRam      = wrn_q;
    assign oAddrRam     = addr_q;
    assign oWrDtRam     = wdt_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oCoeffLoaded = loaded_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader: per-cycle expectations derived from beat counts
// and a behavioural SRAM model. Checks oCoeffSum when FIR_COEFF_CHECKSUM_EN is defined.
module tb_fir_coeff_loader;

    localparam int DW = 16;
    localparam int N  = 33;
    localparam int AW = 6;

    logic                 clk = 1'b0;
    logic                 iRsn = 1'b0;
    logic                 iCoeffUpdate = 1'b0;
    logic                 iCoeffValid = 1'b0;
    logic signed [DW-1:0] iCoeffData = '0;
    logic                 oCoeffReady, oCsnRam, oWrnRam, oBusy, oDone, oCoeffLoaded;
    logic [AW-1:0]        oAddrRam;
    logic [DW-1:0]        oWrDtRam;
`ifdef FIR_COEFF_CHECKSUM_EN
    logic signed [DW+AW-1:0] oCoeffSum;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_coeff_loader #(
        .DATA_WIDTH (DW),
        .NUM_TAPS   (N),
        .ADDR_WIDTH (AW)
    ) dut (
        .iClk_12M     (clk),
        .iRsn         (iRsn),
        .iCoeffUpdate (iCoeffUpdate),
        .iCoeffValid  (iCoeffValid),
        .iCoeffData   (iCoeffData),
        .oCoeffReady  (oCoeffReady),
        .oCsnRam      (oCsnRam),
        .oWrnRam      (oWrnRam),
        .oAddrRam     (oAddrRam),
        .oWrDtRam     (oWrDtRam),
        .oBusy        (oBusy),
        .oDone        (oDone),
`ifdef FIR_COEFF_CHECKSUM_EN
        .oCoeffSum    (oCoeffSum),
`endif
        .oCoeffLoaded (oCoeffLoaded)
    );

    task automatic check_eq(input string tag, input logic signed [63:0] act,
                            input logic signed [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, req, $time);
        end
    endtask

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_csn"}, oCsnRam, 1);
        check_eq({pfx, "_wrn"}, oWrnRam, 1);
        check_eq({pfx, "_addr"}, oAddrRam, 0);
        check_eq({pfx, "_wdata"}, oWrDtRam, 0);
        check_eq({pfx, "_ready"}, oCoeffReady, 0);
        check_eq({pfx, "_busy"}, oBusy, 0);
        check_eq({pfx, "_done"}, oDone, 0);
        check_eq({pfx, "_loaded"}, oCoeffLoaded, 0);
`ifdef FIR_COEFF_CHECKSUM_EN
        check_eq({pfx, "_sum"}, oCoeffSum, 0);
`endif
    endtask

    // dmode: 0 ramp k*3-50, 1 random, 2 all -1.  vmode: 0 always valid, 1 gap every 3rd
    // cycle, 2 random valid.  abort_at: reset after that many beats (0 = never).
    // upd_at: pulse iCoeffUpdate this many cycles into the read sweep (0 = never).
    task automatic run_load(input int dmode, input int vmode, input int abort_at,
                            input int upd_at);
        logic signed [DW-1:0] coeff [1:N];
        logic signed [DW-1:0] mem [0:63];
        longint sum;
        int acc, w_cyc, pend_addr, exp_rd, done_seen, done_cyc;
        bit pend, v, exp_done;

        sum = 0;
        for (int k = 1; k <= N; k++) begin
            if (dmode == 0)      coeff[k] = DW'(k * 3 - 50);
            else if (dmode == 1) coeff[k] = DW'($urandom);
            else                 coeff[k] = -1;
            sum += longint'(coeff[k]);
        end
        // Unwritten locations hold the complement so a missed write is visible on read.
        for (int a = 0; a < 64; a++) mem[a] = (a >= 1 && a <= N) ? ~coeff[a] : '0;

        @(negedge clk);
        iCoeffUpdate = 1'b1;
        iCoeffValid  = 1'($urandom_range(0, 1));
        iCoeffData   = DW'($urandom);
        @(negedge clk);
        iCoeffUpdate = 1'b0;

        acc = 0; w_cyc = 0; pend = 1'b0; pend_addr = 0; done_seen = 0; done_cyc = 0;
        for (int c = 1; c <= 400; c++) begin
            exp_rd   = (w_cyc > 0 && c > w_cyc && c <= w_cyc + N) ? c - w_cyc : 0;
            exp_done = (w_cyc > 0 && c == w_cyc + N + 1);

            check_eq("csn", oCsnRam, (pend || exp_rd > 0) ? 0 : 1);
            if (pend) begin
                check_eq("wr_wrn", oWrnRam, 0);
                check_eq("wr_addr", oAddrRam, pend_addr);
                check_eq("wr_data", $signed(oWrDtRam), coeff[pend_addr]);
            end
            if (exp_rd > 0) begin
                check_eq("rd_wrn", oWrnRam, 1);
                check_eq("rd_addr", oAddrRam, exp_rd);
                check_eq("rd_wdata", oWrDtRam, 0);
                check_eq("sram_coeff", mem[exp_rd], coeff[exp_rd]);
            end
            if (!oCsnRam && !oWrnRam) mem[oAddrRam] = oWrDtRam;
            check_eq("ready", oCoeffReady, (acc < N) ? 1 : 0);
            check_eq("busy", oBusy, (w_cyc == 0 || c <= w_cyc + N + 1) ? 1 : 0);
            check_eq("done", oDone, exp_done ? 1 : 0);
            check_eq("loaded", oCoeffLoaded, (w_cyc > 0 && c >= w_cyc + N + 1) ? 1 : 0);
`ifdef FIR_COEFF_CHECKSUM_EN
            if (exp_done) check_eq("coeff_sum", oCoeffSum, sum);
`endif
            if (oDone) begin
                done_seen++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (w_cyc > 0 && c >= w_cyc + N + 4) break;

            if (abort_at > 0 && acc == abort_at) begin
                iRsn        = 1'b0;
                iCoeffValid = 1'b1;
                @(negedge clk);
                check_reset("abort");
                iRsn        = 1'b1;
                iCoeffValid = 1'b0;
                @(negedge clk);
                check_eq("abort_idle_csn", oCsnRam, 1);
                check_eq("abort_idle_busy", oBusy, 0);
                return;
            end

            if (vmode == 0)      v = 1'b1;
            else if (vmode == 1) v = (c % 3 != 0);
            else                 v = 1'($urandom_range(0, 1));
            iCoeffValid  = v;
            iCoeffData   = (acc < N) ? coeff[acc + 1] : DW'($urandom);
            iCoeffUpdate = (upd_at > 0 && w_cyc > 0 && c == w_cyc + upd_at);
            pend = 1'b0;
            if (v && acc < N) begin
                pend      = 1'b1;
                pend_addr = acc + 1;
                acc++;
                if (acc == N) w_cyc = c + 1;
            end
            @(negedge clk);
        end
        iCoeffValid  = 1'b0;
        iCoeffUpdate = 1'b0;
        check_eq("done_count", done_seen, 1);
        if (vmode == 0) check_eq("done_latency", done_cyc, 2 * N + 2);
    endtask

    initial begin
        iRsn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        iRsn = 1'b1;
        iCoeffValid = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_csn", oCsnRam, 1);
        check_eq("idle_ready", oCoeffReady, 0);
        iCoeffValid = 1'b0;

        run_load(0, 0, 0, 0);
        run_load(1, 1, 0, 0);
        run_load(1, 2, 10, 0);
        run_load(0, 0, 0, 5);
        run_load(2, 2, 0, 0);
        run_load(1, 2, 0, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
